axi_addr_gen: RTL and testbench

Parametrised AXI4 write-address beat generator: accepts one burst on the AW channel and emits a backpressurable stream of per-beat addresses. Each address carries its size, byte-lane offset and last flag, so it can be paired with the W data beats. Supports FIXED, INCR and (optionally) WRAP bursts, narrow transfers, and zero-bubble back-to-back bursts. Sits between the AXI slave front end and the write datapath/strobe logic.

---
 rtl/axi_addr_gen_if.sv | 33 +++
 rtl/axi_addr_gen.sv | 154 +++++++++++++++
 tb/tb_axi_addr_gen.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi_addr_gen_if.sv
// rtl/axi_addr_gen_if.sv - AW command and per-beat address stream bundle for axi_addr_gen
interface axi_addr_gen_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  localparam int LANE_W = $clog2(DATA_WIDTH / 8);

  logic [ADDR_WIDTH-1:0] i_awaddr;
  logic [7:0]            i_awlen;
  logic [2:0]            i_awsize;
  logic [1:0]            i_awburst;
  logic                  i_awvalid;
  logic                  i_awready;
  logic [ADDR_WIDTH-1:0] o_next_addr_data;
  logic [LANE_W-1:0]     o_next_addr_lane;
  logic [2:0]            o_next_addr_size;
  logic                  o_next_addr_last;
  logic                  o_next_addr_valid;
  logic                  o_next_addr_ready;
  logic                  o_err;

  modport master (
    output i_awaddr, i_awlen, i_awsize, i_awburst, i_awvalid, o_next_addr_ready,
    input  i_awready, o_next_addr_data, o_next_addr_lane, o_next_addr_size,
           o_next_addr_last, o_next_addr_valid, o_err
  );

  modport slave (
    input  i_awaddr, i_awlen, i_awsize, i_awburst, i_awvalid, o_next_addr_ready,
    output i_awready, o_next_addr_data, o_next_addr_lane, o_next_addr_size,
           o_next_addr_last, o_next_addr_valid, o_err
  );
endinterface

// File: rtl/axi_addr_gen.sv
// rtl/axi_addr_gen.sv - AXI4 write-address beat generator (FIXED, INCR, narrow, back-to-back)
// WRAP bursts are built only when AXIADDRGEN_WRAP_EN is defined; otherwise WRAP is flagged and run as INCR.
module axi_addr_gen #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic           clk,
  input logic           reset_n,
  axi_addr_gen_if.slave bus
);
  localparam int LANE_W   = $clog2(DATA_WIDTH / 8);
  localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);
  localparam logic [2:0] MAX_SIZE_L = 3'(MAX_SIZE);
  localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            rem_q, rem_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            mode_q, mode_d;
  logic                  err_q, err_d;

  logic                  busy, last, beat_hs, aw_hs, awready;
  logic [2:0]            size_in;
  logic [1:0]            mode_in;
  logic                  illegal_in;
  logic [ADDR_WIDTH-1:0] incr_cur, aligned_next, step_next;

`ifdef AXIADDRGEN_WRAP_EN
  logic [ADDR_WIDTH-1:0] incr_in, span_in, lower_q, span_q;
  logic                  wrap_ok;
`endif

  assign busy    = (state_q == S_BUSY);
  assign last    = busy && (rem_q == 8'd0);
  assign beat_hs = busy && bus.o_next_addr_ready;
  // Idle acceptance is independent of the beat consumer; busy acceptance only on the final handshake.
  assign awready = reset_n && (!busy || (beat_hs && last));
  assign aw_hs   = bus.i_awvalid && awready;

  assign bus.i_awready         = awready;
  assign bus.o_next_addr_data  = addr_q;
  assign bus.o_next_addr_lane  = addr_q[LANE_W-1:0];
  assign bus.o_next_addr_size  = size_q;
  assign bus.o_next_addr_last  = last;
  assign bus.o_next_addr_valid = busy;
  assign bus.o_err             = err_q;

`ifdef AXIADDRGEN_WRAP_EN
  always_comb begin
    incr_in = ONE << size_in;
    span_in = incr_in;
    wrap_ok = 1'b1;
    case (bus.i_awlen)
      8'd1:    span_in = incr_in << 1;
      8'd3:    span_in = incr_in << 2;
      8'd7:    span_in = incr_in << 3;
      8'd15:   span_in = incr_in << 4;
      default: wrap_ok = 1'b0;
    endcase
    if ((bus.i_awaddr & (incr_in - ONE)) != '0) wrap_ok = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lower_q <= '0;
      span_q  <= '0;
    end else if (aw_hs) begin
      lower_q <= bus.i_awaddr & ~(span_in - ONE);
      span_q  <= span_in;
    end
  end
`endif

  // Command decode: every command is accepted, illegal ones are coerced and flagged.
  always_comb begin
    size_in    = (bus.i_awsize > MAX_SIZE_L) ? MAX_SIZE_L : bus.i_awsize;
    illegal_in = (bus.i_awsize > MAX_SIZE_L);
    mode_in    = BURST_INCR;
    case (bus.i_awburst)
      2'b00: mode_in = BURST_FIXED;
      2'b01: mode_in = BURST_INCR;
      2'b10: begin
`ifdef AXIADDRGEN_WRAP_EN
        if (wrap_ok) mode_in = BURST_WRAP;
        else illegal_in = 1'b1;
`else
        illegal_in = 1'b1;
`endif
      end
      default: illegal_in = 1'b1;
    endcase
  end

  always_comb begin
    incr_cur     = ONE << size_q;
    aligned_next = (addr_q & ~(incr_cur - ONE)) + incr_cur;
    step_next    = aligned_next;
    case (mode_q)
      BURST_FIXED: step_next = addr_q;
`ifdef AXIADDRGEN_WRAP_EN
      BURST_WRAP:  step_next = (aligned_next == lower_q + span_q) ? lower_q : aligned_next;
`endif
      default:     step_next = aligned_next;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    size_d  = size_q;
    mode_d  = mode_q;
    err_d   = 1'b0;
    if (aw_hs) begin
      state_d = S_BUSY;
      addr_d  = bus.i_awaddr;
      rem_d   = bus.i_awlen;
      size_d  = size_in;
      mode_d  = mode_in;
      err_d   = illegal_in;
    end else if (beat_hs) begin
      if (last) begin
        state_d = S_IDLE;
      end else begin
        addr_d = step_next;
        rem_d  = rem_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      size_q  <= '0;
      mode_q  <= BURST_INCR;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      size_q  <= size_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_axi_addr_gen.sv
// tb/tb_axi_addr_gen.sv - directed scoreboard bench for axi_addr_gen
module tb_axi_addr_gen;
  typedef struct {
    logic [31:0] addr;
    logic [1:0]  lane;
    logic [2:0]  size;
    logic        last;
  } beat_t;

  logic  clk = 1'b0;
  logic  reset_n = 1'b0;
  int    passed = 0;
  int    total = 0;
  beat_t exp_q[$];

  axi_addr_gen_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi_addr_gen #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic push(input logic [31:0] a, input logic [2:0] sz, input logic lst);
    beat_t b;
    b.addr = a;
    b.lane = a[1:0];
    b.size = sz;
    b.last = lst;
    exp_q.push_back(b);
  endtask

  task automatic drive_aw(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                          input logic [1:0] bt);
    bus.i_awaddr  = a;
    bus.i_awlen   = len;
    bus.i_awsize  = sz;
    bus.i_awburst = bt;
  endtask

  task automatic send_aw(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                         input logic [1:0] bt, input logic err_exp, input string tag);
    int n;
    @(posedge clk); #1;
    drive_aw(a, len, sz, bt);
    bus.i_awvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.i_awready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.i_awready) check({tag, "_aw_timeout"}, bus.i_awready, 1);
    @(posedge clk); #1;
    bus.i_awvalid = 1'b0;
    @(negedge clk);
    check({tag, "_first_valid"}, bus.o_next_addr_valid, 1);
    check({tag, "_err"}, bus.o_err, err_exp);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
    @(negedge clk);
    check({tag, "_idle"}, bus.o_next_addr_valid, 0);
  endtask

  // Scoreboard: every beat handshake pops one expected beat.
  always @(negedge clk) begin
    beat_t e;
    if (reset_n && bus.o_next_addr_valid && bus.o_next_addr_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", bus.o_next_addr_data, e.addr);
        check("beat_lane", bus.o_next_addr_lane, e.lane);
        check("beat_size", bus.o_next_addr_size, e.size);
        check("beat_last", bus.o_next_addr_last, e.last);
      end
    end
  end

  initial begin
    int n;
    bus.i_awaddr = '0;
    bus.i_awlen = '0;
    bus.i_awsize = '0;
    bus.i_awburst = '0;
    bus.i_awvalid = 1'b0;
    bus.o_next_addr_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", bus.o_next_addr_valid, 0);
    check("rst_last", bus.o_next_addr_last, 0);
    check("rst_err", bus.o_err, 0);
    check("rst_data", bus.o_next_addr_data, 0);
    check("rst_size", bus.o_next_addr_size, 0);
    check("rst_awready", bus.i_awready, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("rel_awready", bus.i_awready, 1);

    // INCR aligned
    push(32'h100, 3'd2, 1'b0); push(32'h104, 3'd2, 1'b0);
    push(32'h108, 3'd2, 1'b0); push(32'h10C, 3'd2, 1'b1);
    send_aw(32'h100, 8'd3, 3'd2, 2'b01, 1'b0, "incr");
    drain("incr");

    // Narrow unaligned INCR
    push(32'h203, 3'd1, 1'b0); push(32'h204, 3'd1, 1'b0); push(32'h206, 3'd1, 1'b1);
    send_aw(32'h203, 8'd2, 3'd1, 2'b01, 1'b0, "narrow");
    drain("narrow");

    // WRAP
`ifdef AXIADDRGEN_WRAP_EN
    push(32'h38, 3'd2, 1'b0); push(32'h3C, 3'd2, 1'b0);
    push(32'h30, 3'd2, 1'b0); push(32'h34, 3'd2, 1'b1);
    send_aw(32'h38, 8'd3, 3'd2, 2'b10, 1'b0, "wrap");
`else
    push(32'h38, 3'd2, 1'b0); push(32'h3C, 3'd2, 1'b0);
    push(32'h40, 3'd2, 1'b0); push(32'h44, 3'd2, 1'b1);
    send_aw(32'h38, 8'd3, 3'd2, 2'b10, 1'b1, "wrap");
`endif
    drain("wrap");

    // FIXED, oversized awsize, reserved burst type
    push(32'h600, 3'd2, 1'b0); push(32'h600, 3'd2, 1'b0); push(32'h600, 3'd2, 1'b1);
    send_aw(32'h600, 8'd2, 3'd2, 2'b00, 1'b0, "fixed");
    drain("fixed");
    push(32'h400, 3'd2, 1'b0); push(32'h404, 3'd2, 1'b1);
    send_aw(32'h400, 8'd1, 3'd3, 2'b01, 1'b1, "clamp");
    drain("clamp");
    push(32'h500, 3'd2, 1'b0); push(32'h504, 3'd2, 1'b1);
    send_aw(32'h500, 8'd1, 3'd2, 2'b11, 1'b1, "rsvd");
    drain("rsvd");

    // Back-to-back: A (len 1) then B (len 0), zero bubble
    push(32'h700, 3'd2, 1'b0); push(32'h704, 3'd2, 1'b1); push(32'h800, 3'd2, 1'b1);
    @(posedge clk); #1;
    drive_aw(32'h700, 8'd1, 3'd2, 2'b01);
    bus.i_awvalid = 1'b1;
    @(negedge clk);
    check("b2b_awready_a", bus.i_awready, 1);
    @(posedge clk); #1;
    drive_aw(32'h800, 8'd0, 3'd2, 2'b01);
    @(negedge clk);
    check("b2b_valid1", bus.o_next_addr_valid, 1);
    check("b2b_awready_busy", bus.i_awready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b_valid2", bus.o_next_addr_valid, 1);
    check("b2b_awready_last", bus.i_awready, 1);
    @(posedge clk); #1;
    bus.i_awvalid = 1'b0;
    @(negedge clk);
    check("b2b_valid3", bus.o_next_addr_valid, 1);
    check("b2b_b_data", bus.o_next_addr_data, 32'h800);
    drain("b2b");

    // Backpressure mid-burst
    push(32'h900, 3'd2, 1'b0); push(32'h904, 3'd2, 1'b0);
    push(32'h908, 3'd2, 1'b0); push(32'h90C, 3'd2, 1'b1);
    send_aw(32'h900, 8'd3, 3'd2, 2'b01, 1'b0, "bp");
    @(posedge clk); #1;
    bus.o_next_addr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_hold_data", bus.o_next_addr_data, 32'h904);
      check("bp_hold_last", bus.o_next_addr_last, 0);
      check("bp_awready", bus.i_awready, 0);
    end
    bus.o_next_addr_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.o_next_addr_valid && bus.o_next_addr_last) && n < 20);
    check("bp_awready_last", bus.i_awready, 1);
    drain("bp");

    // Reset on beat 2 of a len-7 burst
    for (int i = 0; i < 8; i++) push(32'hA00 + 32'(4 * i), 3'd2, i == 7);
    send_aw(32'hA00, 8'd7, 3'd2, 2'b01, 1'b0, "rst_mid");
    @(posedge clk);
    @(posedge clk); #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("rstmid_valid", bus.o_next_addr_valid, 0);
    check("rstmid_awready", bus.i_awready, 0);
    check("rstmid_data", bus.o_next_addr_data, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("rstmid_awready_rel", bus.i_awready, 1);
    check("rstmid_valid_rel", bus.o_next_addr_valid, 0);
    push(32'hB00, 3'd2, 1'b0); push(32'hB04, 3'd2, 1'b1);
    send_aw(32'hB00, 8'd1, 3'd2, 2'b01, 1'b0, "post_rst");
    drain("post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
